// File: rtl/data_mem_responder.sv
// Responder side of the data-memory interface: word RAM with byte-lane writes behind a fixed-latency in-order response pipe.
// Define DMEM_STALL_EN to inject pseudo-random grant stalls from an 8-bit LFSR.
module data_mem_responder #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    input  logic [WORD_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [WORD_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [WORD_WIDTH-1:0] data_rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic                  stall;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [WORD_WIDTH-1:0] read_word;
    logic                  unused_addr_bits;

    logic                  pipe_valid [RD_LATENCY];
    logic [WORD_WIDTH-1:0] pipe_data  [RD_LATENCY];

    // Byte offset and bits above the RAM depth are dropped, so addresses alias modulo the depth.
    assign word_idx         = data_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{data_addr_i[WORD_WIDTH-1:ADDR_WIDTH+2], data_addr_i[1:0]};

`ifdef DMEM_STALL_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign data_gnt_o = data_req_i & ~stall & ~rst;
    assign accept     = data_req_i & data_gnt_o;
    assign read_word  = mem[word_idx];

    always_ff @(posedge clk) begin
        if (accept && data_we_i) begin
            for (int n = 0; n < 4; n++) begin
                if (data_be_i[n]) begin
                    mem[word_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Later stages only copy data when a valid entry moves in, so the output holds its last response between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_data[s]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            if (accept) begin
                pipe_data[0] <= data_we_i ? '0 : read_word;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                if (pipe_valid[s-1]) begin
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
        end
    end

    assign data_rvalid_o = pipe_valid[RD_LATENCY-1];
    assign data_rdata_o  = pipe_data[RD_LATENCY-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (latency 1 and 3) share one initiator.
// Build with DMEM_STALL_EN to exercise the stall LFSR against a reference model.
module tb_data_mem_responder;

    localparam int AW    = 10;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        req   = 1'b0;
    logic [31:0] addr  = '0;
    logic        we    = 1'b0;
    logic [3:0]  be    = '0;
    logic [31:0] wdata = '0;

    logic        gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [31:0] rdata_a, rdata_b;

    typedef struct {
        logic [31:0] data;
        int          edge_n;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] model_mem [int];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int grants    = 0;
    int resp_a    = 0;
    int resp_b    = 0;
    int dropped_b = 0;

    logic stall_m;

    data_mem_responder #(.WORD_WIDTH(32), .ADDR_WIDTH(AW), .RD_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt_a),
        .data_rvalid_o(rvalid_a), .data_rdata_o(rdata_a)
    );

    data_mem_responder #(.WORD_WIDTH(32), .ADDR_WIDTH(AW), .RD_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt_b),
        .data_rvalid_o(rvalid_b), .data_rdata_o(rdata_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef DMEM_STALL_EN
    logic [7:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
    assign stall_m = (lfsr_m[1:0] == 2'b00);
`else
    assign stall_m = 1'b0;
`endif

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Pops the scoreboard on every rvalid and checks data, latency and hold behaviour.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_a = '0;
                last_b = '0;
            end else begin
                if (rvalid_a) begin
                    resp_a++;
                    checks++;
                    if (q_a.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_rvalid_a: got rvalid=1 expected 0 at cycle %0d", cyc);
                    end else begin
                        e = q_a.pop_front();
                        checks += 2;
                        if (rdata_a !== e.data) begin
                            errors++;
                            $display("[TB] FAIL rdata_a: got %h expected %h", rdata_a, e.data);
                        end
                        if (cyc !== e.edge_n + LAT_A - 1) begin
                            errors++;
                            $display("[TB] FAIL latency_a: got cycle %0d expected %0d", cyc, e.edge_n + LAT_A - 1);
                        end
                    end
                    last_a = rdata_a;
                end else begin
                    checks++;
                    if (rdata_a !== last_a) begin
                        errors++;
                        $display("[TB] FAIL hold_a: got %h expected %h", rdata_a, last_a);
                    end
                end
                if (rvalid_b) begin
                    resp_b++;
                    checks++;
                    if (q_b.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_rvalid_b: got rvalid=1 expected 0 at cycle %0d", cyc);
                    end else begin
                        e = q_b.pop_front();
                        checks += 2;
                        if (rdata_b !== e.data) begin
                            errors++;
                            $display("[TB] FAIL rdata_b: got %h expected %h", rdata_b, e.data);
                        end
                        if (cyc !== e.edge_n + LAT_B - 1) begin
                            errors++;
                            $display("[TB] FAIL latency_b: got cycle %0d expected %0d", cyc, e.edge_n + LAT_B - 1);
                        end
                    end
                    last_b = rdata_b;
                end else begin
                    checks++;
                    if (rdata_b !== last_b) begin
                        errors++;
                        $display("[TB] FAIL hold_b: got %h expected %h", rdata_b, last_b);
                    end
                end
            end
        end
    endtask

    // Drives one transfer from a negedge, holding it until granted; pushes expectations at the grant.
    task automatic xfer(input logic t_we, input logic [31:0] t_addr, input logic [3:0] t_be,
                        input logic [31:0] t_wdata);
        logic        done;
        logic        exp_gnt;
        logic [31:0] exp_data;
        int          idx;
        int          waited;
        exp_t        e;
        req    = 1'b1;
        addr   = t_addr;
        we     = t_we;
        be     = t_be;
        wdata  = t_wdata;
        done   = 1'b0;
        waited = 0;
        while (!done) begin
            #1;
            exp_gnt = !rst && !stall_m;
            checks++;
            if (gnt_a !== exp_gnt || gnt_b !== exp_gnt) begin
                errors++;
                $display("[TB] FAIL gnt: got %b/%b expected %b", gnt_a, gnt_b, exp_gnt);
            end
            if (exp_gnt) begin
                idx = int'(t_addr[AW+1:2]);
                if (t_we) begin
                    if (!model_mem.exists(idx)) model_mem[idx] = '0;
                    for (int n = 0; n < 4; n++) begin
                        if (t_be[n]) model_mem[idx][8*n +: 8] = t_wdata[8*n +: 8];
                    end
                    exp_data = '0;
                end else begin
                    exp_data = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                end
                e.data   = exp_data;
                e.edge_n = cyc + 1;
                q_a.push_back(e);
                q_b.push_back(e);
                grants++;
                done = 1'b1;
            end
            @(negedge clk);
            waited++;
            if (!done && waited > 64) begin
                errors++;
                $display("[TB] FAIL grant_timeout: got no grant expected grant within 64 cycles");
                done = 1'b1;
            end
        end
    endtask

    task automatic idle();
        req = 1'b0;
        #1;
        checks++;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_gnt: got %b/%b expected 0", gnt_a, gnt_b);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 3;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_gnt: got %b/%b expected 0", tag, gnt_a, gnt_b);
        end
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_rvalid: got %b/%b expected 0", tag, rvalid_a, rvalid_b);
        end
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("[TB] FAIL %s_rdata: got %h/%h expected 0", tag, rdata_a, rdata_b);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 1'b1;
        addr = 32'h40;
        be   = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        req = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        xfer(1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
        xfer(1'b0, 32'h40, 4'hF, 32'h0);
        idle();
        drain();
    endtask

    task automatic test_byte_lanes();
        xfer(1'b1, 32'h80, 4'hF, 32'h11223344);
        xfer(1'b1, 32'h80, 4'b0101, 32'hAABBCCDD);
        xfer(1'b0, 32'h80, 4'h0, 32'h0);
        xfer(1'b1, 32'h80, 4'b0000, 32'hFFFFFFFF);
        xfer(1'b0, 32'h80, 4'hF, 32'h0);
        idle();
        drain();
        checks++;
        if (model_mem[32] !== 32'h11BB33DD) begin
            errors++;
            $display("[TB] FAIL lane_model: got %h expected 11bb33dd", model_mem[32]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) xfer(1'b1, 32'(4 * i), 4'hF, 32'(i + 1));
        for (int i = 0; i < 4; i++) xfer(1'b0, 32'(4 * i), 4'hF, 32'h0);
        idle();
        drain();
    endtask

    task automatic test_wrap();
        xfer(1'b1, 32'h0, 4'hF, 32'h5);
        xfer(1'b0, 32'h1000, 4'hF, 32'h0);
        xfer(1'b0, 32'h2, 4'hF, 32'h0);
        idle();
        drain();
    endtask

    task automatic test_mid_reset();
        xfer(1'b1, 32'h200, 4'hF, 32'h12345678);
        xfer(1'b0, 32'h200, 4'hF, 32'h0);
        #2 rst = 1'b1;
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_a: got %0d pending expected 0", q_a.size());
        end
        dropped_b += q_b.size();
        q_a.delete();
        q_b.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            check_reset_outputs("mid_reset");
        end
        @(negedge clk);
        req = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (6) idle();
        xfer(1'b0, 32'h200, 4'hF, 32'h0);
        idle();
        drain();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int w = 0; w < 16; w++) xfer(1'b1, 32'(32'h100 + 4 * w), 4'hF, $urandom);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) idle();
            a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3))
                + 32'(32'h1000 * $urandom_range(0, 3));
            xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end
        idle();
        drain();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_byte_lanes();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        test_random();
        checks += 2;
        if (resp_a !== grants) begin
            errors++;
            $display("[TB] FAIL resp_count_a: got %0d expected %0d", resp_a, grants);
        end
        if (resp_b + dropped_b !== grants) begin
            errors++;
            $display("[TB] FAIL resp_count_b: got %0d expected %0d", resp_b + dropped_b, grants);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
